// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the immediate detector downstream.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        PC_HOLD    = 3'd0,
        PC_LD_LO   = 3'd1,
        PC_LD_HI   = 3'd2,
        PC_LD_FULL = 3'd3,
        PC_INC     = 3'd4
    } pc_op_t;

    localparam logic [15:0] NOP_WORD     = 16'h0000;
    // Opcode bit that announces a trailing 16-bit immediate word.
    localparam int          IMM_FLAG_BIT = 2;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with half-word loads (reset vector), full load, increment and hold.
// Latency: the new PC is visible one edge after the operation is requested.
// Backpressure: the PC_HOLD operation freezes the PC.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_op_t          op,
    input  logic [15:0]     half,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            case (op)
                PC_LD_LO:   pc[15:0]      <= half;
                // Narrow PCs simply drop the unused top bits of the high half.
                PC_LD_HI:   pc[PC_W-1:16] <= half[PC_W-17:0];
                PC_LD_FULL: pc            <= load_pc;
                PC_INC:     pc            <= pc + ONE;
                default:    pc            <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: loads the PC from the reset vector, then fetches one 16-bit word per cycle.
// Latency: first valid ir 3 edges after reset release; 1 bubble after each redirect.
// Backpressure: stall freezes PC and ir; redirect overrides stall and flushes ir.
module fetch_stage #(
    parameter int          PC_W     = 32,
    parameter int          IMEM_AW  = 20,
    parameter int unsigned RST_VEC  = 0,
    parameter logic [15:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [15:0]        ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    output logic               ir_is_imm,
    output logic               busy
);
    import fetch_stage_pkg::*;

    localparam logic [IMEM_AW-1:0] VEC_LO_ADDR = IMEM_AW'(RST_VEC);
    localparam logic [IMEM_AW-1:0] VEC_HI_ADDR = IMEM_AW'(RST_VEC + 1);

    fetch_state_t    state, state_nxt;
    pc_op_t          pc_op;
    logic [PC_W-1:0] pc;
    logic            imm_next;

    pc_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (pc_op),
        .half    (imem_rdata),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= VEC_LO;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_op     = PC_HOLD;
        imem_addr = pc[IMEM_AW-1:0];
        case (state)
            VEC_LO: begin
                imem_addr = VEC_LO_ADDR;
                pc_op     = PC_LD_LO;
                state_nxt = VEC_HI;
            end
            VEC_HI: begin
                imem_addr = VEC_HI_ADDR;
                pc_op     = PC_LD_HI;
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect)    pc_op = PC_LD_FULL;
                else if (!stall) pc_op = PC_INC;
            end
            default: state_nxt = VEC_LO;
        endcase
    end

    assign busy = (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= NOP_WORD;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            ir_is_imm <= 1'b0;
            imm_next  <= 1'b0;
        end else if (state == RUN) begin
            if (redirect) begin
                // Any pending immediate is dropped so the target starts as an opcode.
                ir        <= NOP_WORD;
                ir_valid  <= 1'b0;
                ir_is_imm <= 1'b0;
                imm_next  <= 1'b0;
            end else if (!stall) begin
                ir        <= imem_rdata;
                ir_pc     <= pc;
                ir_valid  <= 1'b1;
                ir_is_imm <= imm_next;
                imm_next  <= !imm_next && imem_rdata[IMM_FLAG_BIT];
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset vector, immediate tagging, stall, redirect, wrap, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [19:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_is_imm;
    logic        busy;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    assign imem_rdata = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_is_imm   (ir_is_imm),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ir(input string tag, input logic [15:0] w, input logic [31:0] p,
                          input logic v, input logic imm);
        chk({tag, ".ir"},     ir,        w);
        chk({tag, ".ir_pc"},  ir_pc,     p);
        chk({tag, ".valid"},  ir_valid,  v);
        chk({tag, ".is_imm"}, ir_is_imm, imm);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i << 4);
        mem[8'h00] = 16'h0010;
        mem[8'h01] = 16'h0000;
        mem[8'h10] = 16'h0004;
        mem[8'h11] = 16'h0004;
        mem[8'h12] = 16'h0000;
        mem[8'h20] = 16'h0004;
        mem[8'h40] = 16'h0004;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #3;
        chk_ir("rst", 16'h0000, 32'h0, 1'b0, 1'b0);
        chk("rst.busy", busy, 1'b1);
        chk("rst.addr", imem_addr, 20'h0);

        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("vec0.addr", imem_addr, 20'h0);
        step();
        chk("vec1.busy", busy, 1'b1);
        chk("vec1.addr", imem_addr, 20'h1);
        chk("vec1.valid", ir_valid, 1'b0);
        step();
        chk("vec2.busy", busy, 1'b0);
        chk("vec2.addr", imem_addr, 20'h10);
        chk("vec2.valid", ir_valid, 1'b0);

        // 0x10 opcode with flag, 0x11 its immediate, 0x12 plain opcode
        step(); chk_ir("f10", 16'h0004, 32'h10, 1'b1, 1'b0);
        step(); chk_ir("f11", 16'h0004, 32'h11, 1'b1, 1'b1);
        step(); chk_ir("f12", 16'h0000, 32'h12, 1'b1, 1'b0);
        chk("f12.addr", imem_addr, 20'h13);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ir("stall", 16'h0000, 32'h12, 1'b1, 1'b0);
            chk("stall.addr", imem_addr, 20'h13);
        end
        stall = 1'b0;
        step(); chk_ir("f13", 16'h1130, 32'h13, 1'b1, 1'b0);
        step(); chk_ir("f14", 16'h1140, 32'h14, 1'b1, 1'b0);

        redirect = 1'b1; redirect_pc = 32'h20;
        step(); chk_ir("rd20", 16'h0000, 32'h14, 1'b0, 1'b0);
        chk("rd20.addr", imem_addr, 20'h20);
        redirect = 1'b0;
        step(); chk_ir("f20", 16'h0004, 32'h20, 1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); chk_ir("rd40", 16'h0000, 32'h20, 1'b0, 1'b0);
        chk("rd40.addr", imem_addr, 20'h40);
        redirect = 1'b0;
        step(); chk_ir("f40", 16'h0004, 32'h40, 1'b1, 1'b0);
        step(); chk_ir("f41", 16'h1410, 32'h41, 1'b1, 1'b1);

        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h50;
        step(); chk("rdst.valid", ir_valid, 1'b0);
        chk("rdst.addr", imem_addr, 20'h50);
        stall = 1'b0; redirect_pc = 32'h60;
        step(); chk("rd2.valid", ir_valid, 1'b0);
        chk("rd2.addr", imem_addr, 20'h60);
        redirect = 1'b0;
        step(); chk_ir("f60", 16'h1600, 32'h60, 1'b1, 1'b0);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(); chk("rdw.addr", imem_addr, 20'hFFFFF);
        chk("rdw.valid", ir_valid, 1'b0);
        redirect = 1'b0;
        step(); chk_ir("fmax", 16'h1FF0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("fmax.addr", imem_addr, 20'h0);
        step(); chk_ir("fwrap", 16'h0010, 32'h0, 1'b1, 1'b0);
        chk("fwrap.addr", imem_addr, 20'h1);

        #2 rst_n = 1'b0;
        #1;
        chk_ir("arst", 16'h0000, 32'h0, 1'b0, 1'b0);
        chk("arst.busy", busy, 1'b1);
        chk("arst.addr", imem_addr, 20'h0);
        @(negedge clk); rst_n = 1'b1;
        step(); chk("rvec1.addr", imem_addr, 20'h1);
        step(); chk("rvec2.addr", imem_addr, 20'h10);
        chk("rvec2.busy", busy, 1'b0);
        step(); chk_ir("rf10", 16'h0004, 32'h10, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
